// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the decode-stage hazard/stall logic:
// opcode constants, FSM state encoding and decode/hazard bundles.
package hazard_stall_unit_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  // Multi-cycle unit lives in the custom-0 opcode space.
  localparam logic [6:0] OPC_MC     = 7'b0001011;

  localparam logic [2:0] F3_JALR    = 3'b000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BUBBLE  = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic rs1_used;
    logic rs2_used;
    logic is_jalr;
    logic is_mc;
  } dec_t;

  typedef struct packed {
    logic load_use;
    logic jalr_mem;
    logic mc_dep;
  } hazard_t;

endpackage

// File: rtl/hazard_stall_unit_scoreboard.sv
// Single-entry scoreboard tracking the destination of the one in-flight
// multi-cycle op, plus a sticky flag for issuing while one is outstanding.
module mc_scoreboard
  import hazard_stall_unit_pkg::*;
#(
  parameter int REGFILE_LEN = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mc_issue_i,
  input  logic [REGFILE_LEN-1:0] mc_rd_i,
  input  logic                   mc_done_i,
  output logic                   pending_valid_o,
  output logic [REGFILE_LEN-1:0] pending_rd_o,
  output logic                   mc_overrun_o
);

  logic                   valid_q, valid_d;
  logic [REGFILE_LEN-1:0] rd_q, rd_d;
  logic                   ovr_q, ovr_d;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    ovr_d   = ovr_q;
    if (mc_issue_i) begin
      if (valid_q && !mc_done_i) ovr_d = 1'b1;
      // A write to x0 never produces a dependence, so it is not tracked.
      if (mc_rd_i != '0) begin
        valid_d = 1'b1;
        rd_d    = mc_rd_i;
      end else if (mc_done_i) begin
        valid_d = 1'b0;
      end
    end else if (mc_done_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pending_valid_o = valid_q;
  assign pending_rd_o    = rd_q;
  assign mc_overrun_o    = ovr_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detection: load-use, JALR-behind-load and multi-cycle
// dependences, with a small FSM holding stalls that outlast one cycle.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REGFILE_LEN  = 6,
  parameter int INSTR_WIDTH  = 32,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_IF_ID,
  input  logic [REGFILE_LEN-1:0] rs1_IF_ID,
  input  logic [REGFILE_LEN-1:0] rs2_IF_ID,
  input  logic                   mem_read_ID_EX,
  input  logic [REGFILE_LEN-1:0] rd_ID_EX,
  input  logic                   mem_read_EX_MEM,
  input  logic [REGFILE_LEN-1:0] rd_EX_MEM,
  input  logic                   mc_issue,
  input  logic [REGFILE_LEN-1:0] mc_rd,
  input  logic                   mc_done,
  output logic                   stall_IF,
  output logic                   stall_ID,
  output logic                   flush_ID_EX,
  output logic                   pending_valid,
  output logic [REGFILE_LEN-1:0] pending_rd,
  output logic                   mc_overrun
);

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [FUNCT3_WIDTH-1:0] funct3;
  logic                    unused_instr;
  dec_t                    dec;
  hazard_t                 hz;
  state_e                  state_q, state_d;
  logic                    stall;

  assign opcode       = instr_IF_ID[OPCODE_WIDTH-1:0];
  assign funct3       = instr_IF_ID[12 +: FUNCT3_WIDTH];
  assign unused_instr = ^{instr_IF_ID[INSTR_WIDTH-1:12+FUNCT3_WIDTH],
                          instr_IF_ID[11:OPCODE_WIDTH]};

  // Source operands come from dedicated ports; only usage is decoded here.
  always_comb begin
    dec          = '0;
    dec.rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    dec.rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    dec.is_jalr  = (opcode == OPC_JALR) && (funct3 == F3_JALR);
    dec.is_mc    = (opcode == OPC_MC);
  end

  function automatic logic src_hit(input logic [REGFILE_LEN-1:0] rd,
                                   input logic [REGFILE_LEN-1:0] rs1,
                                   input logic [REGFILE_LEN-1:0] rs2,
                                   input logic                   rs1_used,
                                   input logic                   rs2_used);
    return (rd != '0) && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
  endfunction

  always_comb begin
    hz          = '0;
    hz.load_use = mem_read_ID_EX &&
                  src_hit(rd_ID_EX, rs1_IF_ID, rs2_IF_ID, dec.rs1_used, dec.rs2_used);
    hz.jalr_mem = dec.is_jalr && mem_read_EX_MEM &&
                  src_hit(rd_EX_MEM, rs1_IF_ID, rs2_IF_ID, 1'b1, 1'b0);
    // Only one multi-cycle op may be in flight, so a second one must wait.
    hz.mc_dep   = pending_valid &&
                  (dec.is_mc ||
                   src_hit(pending_rd, rs1_IF_ID, rs2_IF_ID, dec.rs1_used, dec.rs2_used));
  end

  mc_scoreboard #(
    .REGFILE_LEN (REGFILE_LEN)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .mc_issue_i      (mc_issue),
    .mc_rd_i         (mc_rd),
    .mc_done_i       (mc_done),
    .pending_valid_o (pending_valid),
    .pending_rd_o    (pending_rd),
    .mc_overrun_o    (mc_overrun)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // BUBBLE covers the second cycle of a JALR waiting on a load that was in EX;
  // MC_WAIT holds until the scoreboard entry has retired.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (hz.mc_dep)                        state_d = ST_MC_WAIT;
        else if (hz.load_use && dec.is_jalr)  state_d = ST_BUBBLE;
      end
      ST_BUBBLE:                              state_d = ST_RUN;
      ST_MC_WAIT: if (!pending_valid)         state_d = ST_RUN;
      default:                                state_d = ST_RUN;
    endcase
  end

  assign stall = !rst && (hz.load_use || hz.jalr_mem || hz.mc_dep ||
                          state_q == ST_BUBBLE || state_q == ST_MC_WAIT);

  assign stall_IF    = stall;
  assign stall_ID    = stall;
  assign flush_ID_EX = stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a table of single-cycle decode
// vectors plus hand-written multi-cycle stall and scoreboard sequences.
module tb_hazard_stall_unit;

  localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_OP = 7'b0110011, T_STORE = 7'b0100011;
  localparam logic [6:0] T_BR = 7'b1100011, T_IMM = 7'b0010011, T_MC = 7'b0001011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_IF_ID;
  logic [5:0]  rs1_IF_ID, rs2_IF_ID, rd_ID_EX, rd_EX_MEM, mc_rd, pending_rd;
  logic        mem_read_ID_EX, mem_read_EX_MEM, mc_issue, mc_done;
  logic        stall_IF, stall_ID, flush_ID_EX, pending_valid, mc_overrun;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .instr_IF_ID(instr_IF_ID),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .mem_read_ID_EX(mem_read_ID_EX), .rd_ID_EX(rd_ID_EX),
    .mem_read_EX_MEM(mem_read_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID_EX(flush_ID_EX),
    .pending_valid(pending_valid), .pending_rd(pending_rd), .mc_overrun(mc_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [5:0] rs1;
    logic [5:0] rs2;
    logic       mr_ex;
    logic [5:0] rd_ex;
    logic       mr_mem;
    logic [5:0] rd_mem;
    logic       stall;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_stall(input string nm, input logic exp);
    chk(nm, {29'd0, stall_IF, stall_ID, flush_ID_EX}, {29'd0, {3{exp}}});
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [5:0] r1, input logic [5:0] r2);
    instr_IF_ID = {17'd0, f3, 5'd0, op};
    rs1_IF_ID   = r1;
    rs2_IF_ID   = r2;
  endtask

  task automatic idle();
    set_instr(T_IMM, 3'd0, 6'd0, 6'd0);
    mem_read_ID_EX = 0; rd_ID_EX = 0; mem_read_EX_MEM = 0; rd_EX_MEM = 0;
    mc_issue = 0; mc_rd = 0; mc_done = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    //           op       f3    rs1 rs2 mrEX rdEX mrMEM rdMEM stall
    vecs[0]  = '{T_OP,    3'd0, 6'd5, 6'd7, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1};
    vecs[1]  = '{T_OP,    3'd0, 6'd7, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1};
    vecs[2]  = '{T_IMM,   3'd0, 6'd7, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0};
    vecs[3]  = '{T_LUI,   3'd0, 6'd5, 6'd0, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0};
    vecs[4]  = '{T_AUIPC, 3'd0, 6'd5, 6'd0, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0};
    vecs[5]  = '{T_JAL,   3'd0, 6'd5, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0};
    vecs[6]  = '{T_STORE, 3'd2, 6'd1, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1};
    vecs[7]  = '{T_BR,    3'd0, 6'd5, 6'd3, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1};
    vecs[8]  = '{T_OP,    3'd0, 6'd0, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0};
    vecs[9]  = '{T_OP,    3'd0, 6'd5, 6'd7, 1'b0, 6'd0, 1'b1, 6'd5, 1'b0};
    vecs[10] = '{T_JALR,  3'd0, 6'd5, 6'd0, 1'b0, 6'd0, 1'b1, 6'd5, 1'b1};
    vecs[11] = '{T_JALR,  3'd1, 6'd5, 6'd0, 1'b0, 6'd0, 1'b1, 6'd5, 1'b0};
    vecs[12] = '{T_JALR,  3'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0};
    vecs[13] = '{T_JALR,  3'd0, 6'd5, 6'd0, 1'b0, 6'd0, 1'b1, 6'd6, 1'b0};
    vecs[14] = '{T_OP,    3'd0, 6'd5, 6'd7, 1'b0, 6'd5, 1'b0, 6'd0, 1'b0};
    vecs[15] = '{T_MC,    3'd0, 6'd5, 6'd0, 1'b1, 6'd5, 1'b0, 6'd0, 1'b1};
    vecs[16] = '{T_MC,    3'd0, 6'd5, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0};

    // Reset: hazards driven at the inputs must not leak through.
    rst = 1; idle(); tick();
    set_instr(T_OP, 3'd0, 6'd5, 6'd7);
    mem_read_ID_EX = 1; rd_ID_EX = 5; mc_issue = 1; mc_rd = 9;
    #2;
    chk_stall("reset_stall", 1'b0);
    tick();
    chk("reset_pending", {31'd0, pending_valid}, 32'd0);
    chk("reset_overrun", {31'd0, mc_overrun}, 32'd0);
    chk_stall("reset_stall2", 1'b0);
    idle(); rst = 0; tick();

    // Single-cycle decode table; inputs return to idle before each edge.
    for (int i = 0; i < NV; i++) begin
      set_instr(vecs[i].op, vecs[i].f3, vecs[i].rs1, vecs[i].rs2);
      mem_read_ID_EX = vecs[i].mr_ex;  rd_ID_EX  = vecs[i].rd_ex;
      mem_read_EX_MEM = vecs[i].mr_mem; rd_EX_MEM = vecs[i].rd_mem;
      #2;
      chk_stall($sformatf("vec%0d", i), vecs[i].stall);
      idle(); tick();
    end

    // Load-use: one cycle.
    set_instr(T_OP, 3'd0, 6'd5, 6'd7); mem_read_ID_EX = 1; rd_ID_EX = 5; #2;
    chk_stall("lu_c0", 1'b1);
    tick(); mem_read_ID_EX = 0; rd_ID_EX = 0; mem_read_EX_MEM = 1; rd_EX_MEM = 5; #2;
    chk_stall("lu_c1", 1'b0);
    idle(); tick();

    // JALR behind load in EX: two cycles.
    set_instr(T_JALR, 3'd0, 6'd5, 6'd0); mem_read_ID_EX = 1; rd_ID_EX = 5; #2;
    chk_stall("jx_c0", 1'b1);
    tick(); mem_read_ID_EX = 0; rd_ID_EX = 0; mem_read_EX_MEM = 1; rd_EX_MEM = 5; #2;
    chk_stall("jx_c1", 1'b1);
    tick(); mem_read_EX_MEM = 0; rd_EX_MEM = 0; #2;
    chk_stall("jx_c2", 1'b0);
    idle(); tick();

    // Second cycle held by the FSM alone, with no load visible in MEM.
    set_instr(T_JALR, 3'd0, 6'd5, 6'd0); mem_read_ID_EX = 1; rd_ID_EX = 5;
    tick(); mem_read_ID_EX = 0; rd_ID_EX = 0; #2;
    chk_stall("bubble_only", 1'b1);
    tick(); #2;
    chk_stall("bubble_done", 1'b0);
    idle(); tick();

    // JALR behind load in MEM: one cycle.
    set_instr(T_JALR, 3'd0, 6'd5, 6'd0); mem_read_EX_MEM = 1; rd_EX_MEM = 5; #2;
    chk_stall("jm_c0", 1'b1);
    tick(); mem_read_EX_MEM = 0; rd_EX_MEM = 0; #2;
    chk_stall("jm_c1", 1'b0);
    idle(); tick();

    // Multi-cycle dependence: issue x9 at c0, use at c3, done at c6.
    mc_issue = 1; mc_rd = 9; #2;
    chk_stall("mc_c0", 1'b0);
    tick(); mc_issue = 0; mc_rd = 0; #2;
    chk("mc_pv_c1", {31'd0, pending_valid}, 32'd1);
    chk("mc_rd_c1", {26'd0, pending_rd}, 32'd9);
    chk_stall("mc_c1", 1'b0);
    tick(); tick();
    set_instr(T_OP, 3'd0, 6'd9, 6'd2); #2;
    chk_stall("mc_c3", 1'b1);
    tick(); #2; chk_stall("mc_c4", 1'b1);
    tick(); #2; chk_stall("mc_c5", 1'b1);
    tick(); mc_done = 1; #2;
    chk_stall("mc_c6", 1'b1);
    chk("mc_pv_c6", {31'd0, pending_valid}, 32'd1);
    tick(); mc_done = 0; #2;
    chk("mc_pv_c7", {31'd0, pending_valid}, 32'd0);
    chk_stall("mc_c7", 1'b1);
    tick(); #2;
    chk_stall("mc_c8", 1'b0);
    idle(); tick();

    // A second multi-cycle op waits for the first regardless of registers.
    mc_issue = 1; mc_rd = 12;
    tick(); mc_issue = 0; mc_rd = 0;
    set_instr(T_MC, 3'd0, 6'd1, 6'd2); mc_done = 1; #2;
    chk_stall("mc2_c1", 1'b1);
    tick(); mc_done = 0; #2;
    chk_stall("mc2_c2", 1'b1);
    tick(); #2;
    chk_stall("mc2_c3", 1'b0);
    idle(); tick();

    // Issue and done together: issue wins.
    mc_issue = 1; mc_rd = 8;
    tick(); mc_rd = 4; mc_done = 1;
    tick(); idle(); #2;
    chk("same_pv", {31'd0, pending_valid}, 32'd1);
    chk("same_rd", {26'd0, pending_rd}, 32'd4);
    chk("same_ovr", {31'd0, mc_overrun}, 32'd0);
    mc_done = 1; tick(); #2;
    chk("done_pv", {31'd0, pending_valid}, 32'd0);
    tick(); mc_done = 0; #2;
    chk("done_idle_pv", {31'd0, pending_valid}, 32'd0);
    chk("done_idle_ovr", {31'd0, mc_overrun}, 32'd0);

    // Issue to x0 is not tracked.
    mc_issue = 1; mc_rd = 0; tick(); idle(); #2;
    chk("x0_issue_pv", {31'd0, pending_valid}, 32'd0);

    // Overrun: second issue while pending.
    mc_issue = 1; mc_rd = 10; tick();
    mc_rd = 11; tick(); idle(); #2;
    chk("ovr_set", {31'd0, mc_overrun}, 32'd1);
    chk("ovr_rd", {26'd0, pending_rd}, 32'd11);
    mc_done = 1; tick(); mc_done = 0; tick(); tick(); #2;
    chk("ovr_held", {31'd0, mc_overrun}, 32'd1);
    chk("ovr_pv_clr", {31'd0, pending_valid}, 32'd0);

    // Load into x0 then dependent use.
    set_instr(T_OP, 3'd0, 6'd0, 6'd3); mem_read_ID_EX = 1; rd_ID_EX = 0; #2;
    chk_stall("x0_load", 1'b0);
    idle(); tick();

    // Reset while in MC_WAIT.
    mc_issue = 1; mc_rd = 13; tick(); mc_issue = 0; mc_rd = 0;
    set_instr(T_OP, 3'd0, 6'd13, 6'd0); tick(); #2;
    chk_stall("mcw_pre", 1'b1);
    rst = 1; #1;
    chk_stall("mcw_rst_stall", 1'b0);
    chk("mcw_rst_pv", {31'd0, pending_valid}, 32'd0);
    chk("mcw_rst_ovr", {31'd0, mc_overrun}, 32'd0);
    tick(); rst = 0; #2;
    chk_stall("mcw_post", 1'b0);
    tick(); #2;
    chk_stall("mcw_post2", 1'b0);
    chk("mcw_post_pv", {31'd0, pending_valid}, 32'd0);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
